montgomery_mul_hs: RTL and testbench
====================================

// Module: montgomery_mul_hs
// PURPOSE
// - Parametrised radix-2 Montgomery modular multiplier: out_result = X*Y*2^-W mod N.
// - Iterative datapath, one operand bit per cycle, with valid/ready handshakes on input and output.
// - Flags an even modulus as an error; optionally also flags out-of-range operands.
// - Building block for modexp and ECC field arithmetic in the toolbox.
// PARAMETERS
// - W    16  operand/modulus width in bits (W >= 4); Montgomery radix R = 2^W
// PORTS
// - clk         in   1  clock, rising edge
// - rst         in   1  reset, asynchronous, active-high
// - in_valid    in   1  operand set valid
// - in_ready    out  1  block can accept operands
// - in_n        in   W  modulus N (must be odd; full W bits usable)
// - in_x        in   W  multiplicand X
// - in_y        in   W  multiplier Y (must be < N)
// - out_valid   out  1  result valid
// - out_ready   in   1  consumer accepts result
// - out_result  out  W  X*Y*R^-1 mod N, always < N when out_err=0
// - out_err     out  1  operation rejected; out_result=0
// BEHAVIOUR
// - Reset: in_ready=0 during reset, 1 from the first clk after release; out_valid=0, out_result=0, out_err=0, state=IDLE, all internal regs 0.
// - States: IDLE -> ITER -> FINAL -> DONE -> IDLE; error path IDLE -> DONE.
// - IDLE: in_ready=1. in_valid&&in_ready latches N, X, Y; T<=0; bit counter<=0.
//   If in_n[0]==0: go to DONE with out_err=1, out_result=0. Otherwise go to ITER.
// - ITER, exactly W cycles, i=0..W-1:
//   q = T[0]^(X[i]&Y[0]); T <= (T + (X[i]?Y:0) + (q?N:0)) >> 1.
// - Width rules: T register is W+1 bits and stays < 2N; the pre-shift sum is W+2 bits; no truncation is allowed.
// - FINAL, 1 cycle: out_result <= (T >= N) ? T-N : T (compare is >=, not >); out_err<=0.
// - DONE: out_valid=1. out_result/out_err stay stable until out_valid&&out_ready, then IDLE next cycle.
// - Latency: accept edge to out_valid high is W+2 cycles; error path is 1 cycle.
// - in_ready=0 in ITER/FINAL/DONE; in_valid is ignored there and the latched operands are unaffected.
// - No same-cycle turnaround: a new accept happens no earlier than the cycle after the result handshake.
// - out_ready is ignored when out_valid=0. out_ready tied high gives a result every W+3 cycles.
// - rst asserted mid-operation: immediate abort, all outputs return to reset values, the partial result is discarded.
// - Y >= N without checking: result is unspecified; X >= N is mathematically fine (result is congruent and < N).
// CONFIGURATION
// - MONT_RANGE_CHECK_EN defined: at accept, (in_x >= in_n) or (in_y >= in_n) gives the error path (out_err=1, out_result=0, 1-cycle latency).
// - The even-N check still applies, and takes no precedence difference; any failure means error.
// - MONT_RANGE_CHECK_EN undefined: no comparators; only even N is rejected; X >= N is computed normally.
// TESTING (W=8, R=256, N=97, R mod N=62, R^-1 mod N=36)
// - N=97,X=5,Y=7, out_ready=1 -> out_valid exactly 10 cycles after accept, out_result=96, out_err=0.
// - N=97,X=62,Y=7 -> 7.
// - N=97,X=0,Y=50 -> 0.
// - N=97,X=96,Y=96 -> 36; checks T >= N boundary handling.
// - N=96 (even), any X/Y -> out_valid 1 cycle after accept, out_err=1, out_result=0.
// - N=97,X=100,Y=7: with MONT_RANGE_CHECK_EN -> out_err=1, out_result=0; without it -> out_result=77.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result stable, in_ready=0, in_valid pulses ignored.
//   Then release out_ready -> in_ready=1 on the next cycle.
// - Reset asserted during ITER (cycle 4) -> out_valid=0, in_ready=1 after release; the next op N=97,X=5,Y=7 -> 96.
// - Random: 1000 ops with odd N, Y < N, random stalls on both sides -> compare against the reference model X*Y*inv(R) mod N.

Source files
------------

// File: rtl/montgomery_mul_hs.sv
// -----------------------------------------------------------------------------
// montgomery_mul_hs
//
// Purpose:
//   Radix-2 Montgomery modular multiplier. It computes
//   out_result = X * Y * 2^-W mod N and processes one multiplicand bit per
//   clock. Operands enter on a valid/ready handshake and the result leaves
//   on a second valid/ready handshake. An even modulus is rejected with
//   out_err.
//
// Optional feature:
//   If MONT_RANGE_CHECK_EN is defined, the block also rejects X >= N or
//   Y >= N at accept time. This uses the same one-cycle error path as the
//   even-modulus check. If the macro is undefined, no range comparators are
//   built.
//
// Parameters:
//   W           operand / modulus width in bits (W >= 4); radix R = 2^W
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   in_valid    in   1   operand set valid
//   in_ready    out  1   block can accept operands (registered)
//   in_n        in   W   modulus N (odd)
//   in_x        in   W   multiplicand X
//   in_y        in   W   multiplier Y (< N)
//   out_valid   out  1   result valid (registered)
//   out_ready   in   1   consumer accepts result
//   out_result  out  W   X*Y*R^-1 mod N, or 0 on error
//   out_err     out  1   operation rejected
//
// Timing:
//   The accept edge comes first. The result becomes valid in the (W+2)th
//   cycle after the accept edge. When an operation is rejected, the result
//   becomes valid in the first cycle after the accept edge.
// -----------------------------------------------------------------------------
module montgomery_mul_hs #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_n,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_out_result;
  logic            r_out_err;
  logic [W-1:0]    r_n;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  // The accumulator stays below 2N, so it needs one bit more than N.
  logic [W:0]      r_t;
  logic [CW-1:0]   r_bit_cnt;

  logic            w_accept;
  logic            w_range_bad;
  logic            w_reject;
  logic            w_xi;
  logic            w_q;
  logic [W+1:0]    w_add_y;
  logic [W+1:0]    w_add_n;
  logic [W+1:0]    w_sum;
  logic [W:0]      w_t_next;
  logic            w_t_ge_n;
  logic [W:0]      w_t_diff;
  logic [W-1:0]    w_final;

  // ---------------------------------------------------------------------------
  // Operand screening at accept time
  // ---------------------------------------------------------------------------
`ifdef MONT_RANGE_CHECK_EN
  assign w_range_bad = (in_x >= in_n) || (in_y >= in_n);
`else
  assign w_range_bad = 1'b0;
`endif

  // Any failed check sends the operation down the error path. No check takes
  // priority over another.
  assign w_reject = ~in_n[0] | w_range_bad;

  // in_ready is only ever high in IDLE, so no separate state test is needed.
  assign w_accept = in_valid & r_in_ready;

  // ---------------------------------------------------------------------------
  // One Montgomery step per ITER cycle
  // ---------------------------------------------------------------------------
  assign w_xi = r_x[r_bit_cnt];

  // q is chosen so that the sum is even. The right shift is then an exact
  // division by 2.
  assign w_q = r_t[0] ^ (w_xi & r_y[0]);

  assign w_add_y = w_xi ? {2'b00, r_y} : '0;
  assign w_add_n = w_q  ? {2'b00, r_n} : '0;

  // T < 2N, Y < N and N < 2^W, so the sum is below 4N < 2^(W+2). The sum
  // therefore fits in W+2 bits and nothing is lost.
  assign w_sum    = {1'b0, r_t} + w_add_y + w_add_n;
  assign w_t_next = (W+1)'(w_sum >> 1);

  // ---------------------------------------------------------------------------
  // Final conditional subtraction
  // ---------------------------------------------------------------------------
  // The test is >= so that T == N reduces to 0. Both possible results are
  // below N, so they fit in W bits.
  assign w_t_ge_n = (r_t >= {1'b0, r_n});
  assign w_t_diff = r_t - {1'b0, r_n};
  assign w_final  = W'(w_t_ge_n ? w_t_diff : r_t);

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
      r_n          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_t          <= '0;
      r_bit_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_n        <= in_n;
            r_x        <= in_x;
            r_y        <= in_y;
            r_t        <= '0;
            r_bit_cnt  <= '0;
            if (w_reject) begin
              r_out_valid  <= 1'b1;
              r_out_err    <= 1'b1;
              r_out_result <= '0;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_ITER;
            end
          end else begin
            // After reset is released, the first edge raises in_ready.
            r_in_ready <= 1'b1;
          end
        end

        S_ITER: begin
          r_t       <= w_t_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= S_FINAL;
          end
        end

        S_FINAL: begin
          r_out_result <= w_final;
          r_out_err    <= 1'b0;
          r_out_valid  <= 1'b1;
          r_state      <= S_DONE;
        end

        S_DONE: begin
          // Hold the result until it is taken. The block goes back to IDLE
          // ready to accept, but the next accept cannot happen before the
          // following edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_montgomery_mul_hs.sv
// -----------------------------------------------------------------------------
// tb_montgomery_mul_hs
//
// Self-checking bench for montgomery_mul_hs with W = 8 (R = 256).
// It uses directed vectors with hand-computed expected values. For N = 97,
// R^-1 mod N is 36. A random phase follows, which compares results against a
// reference model that works by direct modular arithmetic.
// Latency is counted as the index of the cycle after the accept edge in which
// out_valid is first seen. The first cycle after that edge counts as 1.
// -----------------------------------------------------------------------------
module tb_montgomery_mul_hs;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_n = '0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  montgomery_mul_hs #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_n       (in_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: X*Y*R^-1 mod N. R^-1 is found by exhaustive search.
  function automatic logic [W-1:0] ref_mont(input logic [W-1:0] n, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    int unsigned nn, xx, yy, rinv, prod;
    nn = n; xx = x; yy = y;
    rinv = 0;
    for (int unsigned r = 1; r < nn; r++) begin
      if (((32'd1 << W) * r) % nn == 1) rinv = r;
    end
    prod = (xx * yy) % nn;
    return W'((prod * rinv) % nn);
  endfunction

  // Runs one complete transaction. The caller chooses the input-side delay
  // and how many cycles out_ready is held low once the result is valid.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall_in, input int stall_out,
                        output logic [W-1:0] res, output logic err, output int lat);
    int guard;
    res = '0; err = 1'b0; lat = 0;
    repeat (stall_in) @(negedge clk);
    in_n = n; in_x = x; in_y = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) begin
      check("result_timeout", out_valid, 1);
      return;
    end
    res = out_result;
    err = out_err;
    repeat (stall_out) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    $display("op N=%0d X=%0d Y=%0d -> result=%0d err=%0d latency=%0d", n, x, y, res, err, lat);
  endtask

  initial begin
    logic [W-1:0] res;
    logic         err;
    int           lat;
    logic [W-1:0] rn, rx, ry;
    logic         exp_err;
    int           t, first, second;
    logic         prev;

    // ---------------- reset state ----------------
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rel_in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_after_edge", in_ready, 1);

    // ---------------- directed vectors ----------------
    run_op(8'd97, 8'd5, 8'd7, 0, 0, res, err, lat);
    check("n97_x5_y7_result", res, 96);
    check("n97_x5_y7_err", err, 0);
    check("n97_x5_y7_latency", lat, 10);

    run_op(8'd97, 8'd62, 8'd7, 1, 0, res, err, lat);
    check("n97_x62_y7_result", res, 7);

    run_op(8'd97, 8'd0, 8'd50, 0, 1, res, err, lat);
    check("n97_x0_y50_result", res, 0);

    run_op(8'd97, 8'd96, 8'd96, 0, 0, res, err, lat);
    check("n97_x96_y96_result", res, 36);
    check("n97_x96_y96_err", err, 0);

    run_op(8'd96, 8'd5, 8'd7, 0, 0, res, err, lat);
    check("even_n_err", err, 1);
    check("even_n_result", res, 0);
    check("even_n_latency", lat, 1);

    // A good operation after an error must clear out_err.
    run_op(8'd97, 8'd5, 8'd7, 0, 0, res, err, lat);
    check("after_err_result", res, 96);
    check("after_err_err", err, 0);

    run_op(8'd97, 8'd100, 8'd7, 0, 0, res, err, lat);
`ifdef MONT_RANGE_CHECK_EN
    check("x_out_of_range_err", err, 1);
    check("x_out_of_range_result", res, 0);
    check("x_out_of_range_latency", lat, 1);
`else
    check("x_ge_n_err", err, 0);
    check("x_ge_n_result", res, 77);
    check("x_ge_n_latency", lat, 10);
`endif

    // ---------------- backpressure ----------------
    @(negedge clk);
    in_n = 8'd97; in_x = 8'd5; in_y = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_n = 8'd97; in_x = 8'd1; in_y = 8'd1;
      @(negedge clk);
      check("bp_result_stable", out_result, 96);
      check("bp_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after_release", in_ready, 1);
    check("bp_valid_dropped", out_valid, 0);
    $display("op N=97 X=5 Y=7 backpressured -> result=96 expected");

    // ---------------- throughput with out_ready tied high ----------------
    @(negedge clk);
    out_ready = 1'b1;
    in_n = 8'd97; in_x = 8'd5; in_y = 8'd7; in_valid = 1'b1;
    t = 0; first = -1; second = -1; prev = 1'b0;
    for (int k = 0; k < 60 && second < 0; k++) begin
      @(negedge clk);
      t++;
      if (out_valid && !prev) begin
        if (first < 0) first = t;
        else second = t;
      end
      prev = out_valid;
    end
    check("throughput_period", second - first, W + 3);
    $display("op streaming N=97 X=5 Y=7 -> period=%0d", second - first);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;

    // ---------------- reset in the middle of ITER ----------------
    @(negedge clk);
    in_n = 8'd97; in_x = 8'd5; in_y = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_result", out_result, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1);
    check("midrst_out_valid_after", out_valid, 0);
    run_op(8'd97, 8'd5, 8'd7, 0, 0, res, err, lat);
    check("midrst_next_result", res, 96);

    // ---------------- random operations with stalls ----------------
    for (int k = 0; k < 1000; k++) begin
      rn = W'($urandom_range(3, 255)) | 8'd1;
      rx = W'($urandom_range(0, 255));
      ry = W'($urandom_range(0, int'(rn) - 1));
`ifdef MONT_RANGE_CHECK_EN
      exp_err = (rx >= rn);
`else
      exp_err = 1'b0;
`endif
      run_op(rn, rx, ry, $urandom_range(0, 3), $urandom_range(0, 3), res, err, lat);
      check("rand_err", err, exp_err);
      check("rand_result", res, exp_err ? '0 : ref_mont(rn, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
